// File: rtl/timed_pulse_gen.sv
// timed_pulse_gen: drives `pulse` high for exactly `dur` clock cycles after a
// start request, then emits a one-cycle `done` strobe. All outputs are
// registered; the FSM computes next-state and next-output values and a single
// register stage holds both.
//
// Optional feature: define PULSE_REPEAT_EN to add the `rep` input and a GAP
// state. This produces a square wave with `dur` cycles high and `dur` cycles
// low for as long as `rep` is held.
module timed_pulse_gen #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dur,
    input  logic             abort,
`ifdef PULSE_REPEAT_EN
    input  logic             rep,
`endif
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

`ifdef PULSE_REPEAT_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
`endif

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dur_q, dur_d;
    logic             pulse_d, busy_d, done_d;
    logic [WIDTH-1:0] rem_d;

    // Next-state and next-output logic; outputs are registered below, so no
    // input reaches an output without passing through a flop.
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so no
        // path through the block leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        dur_d   = dur_q;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rem_d   = '0;

        case (state_q)
            IDLE: begin
                // abort outranks start; a zero-length request completes at once
                if (start && !abort) begin
                    dur_d = dur;
                    if (dur != '0) begin
                        state_d = ACTIVE;
                        pulse_d = 1'b1;
                        busy_d  = 1'b1;
                        rem_d   = dur;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ACTIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (remaining == ONE) begin
`ifdef PULSE_REPEAT_EN
                    if (rep) begin
                        // Low half of the square wave: still busy, reload count
                        state_d = GAP;
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                        rem_d   = dur_q;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    pulse_d = 1'b1;
                    busy_d  = 1'b1;
                    rem_d   = remaining - ONE;
                end
            end

            // One-cycle completion; start and abort are both ignored here
            DONE: begin
                state_d = IDLE;
            end

`ifdef PULSE_REPEAT_EN
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (remaining == ONE) begin
                    if (rep) begin
                        state_d = ACTIVE;
                        pulse_d = 1'b1;
                        busy_d  = 1'b1;
                        rem_d   = dur_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    busy_d = 1'b1;
                    rem_d  = remaining - ONE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched duration and registered outputs; async reset clears all
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            dur_q     <= '0;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            pulse     <= pulse_d;
            busy      <= busy_d;
            done      <= done_d;
            remaining <= rem_d;
        end
    end

endmodule

// File: tb/tb_timed_pulse_gen.sv
// tb_timed_pulse_gen: scoreboard bench for timed_pulse_gen. Stimulus drives
// inputs on the falling edge and pushes the hand-computed output tuple expected
// after the next rising edge. A monitor pops and compares one entry per cycle,
// 1 time unit after each rising edge.
module tb_timed_pulse_gen;

    localparam int W = 6;

    typedef struct packed {
        logic         pulse;
        logic         busy;
        logic         done;
        logic [W-1:0] rem;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dur = '0;
    logic         abort = 1'b0;
    logic         rep = 1'b0;
    logic         pulse, busy, done;
    logic [W-1:0] remaining;

    int   checks = 0;
    int   errors = 0;
    int   cyc_idx = 0;
    exp_t exp_q[$];

    timed_pulse_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dur       (dur),
        .abort     (abort),
`ifdef PULSE_REPEAT_EN
        .rep       (rep),
`endif
        .pulse     (pulse),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got pulse=%0b busy=%0b done=%0b remaining=%0d, expected pulse=%0b busy=%0b done=%0b remaining=%0d",
                     name, got.pulse, got.busy, got.done, got.rem,
                     want.pulse, want.busy, want.done, want.rem);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic b, input logic d, input int r);
        exp_t e;
        e.pulse = p;
        e.busy  = b;
        e.done  = d;
        e.rem   = W'(r);
        return e;
    endfunction

    function automatic exp_t act(input int r);
        return mk(1'b1, 1'b1, 1'b0, r);
    endfunction

    function automatic exp_t idle();
        return mk(1'b0, 1'b0, 1'b0, 0);
    endfunction

    function automatic exp_t fin();
        return mk(1'b0, 1'b0, 1'b1, 0);
    endfunction

    // Drive one cycle of inputs and record the outputs expected after the next edge
    task automatic cyc(input logic st, input int d, input logic ab, input logic rp, input exp_t e);
        @(negedge clk);
        start = st;
        dur   = W'(d);
        abort = ab;
        rep   = rp;
        exp_q.push_back(e);
    endtask

    // Full pulse of length d; hold keeps start asserted for the whole pulse
    task automatic pulse_seq(input int d, input logic hold);
        cyc(1'b1, d, 1'b0, 1'b0, act(d));
        for (int r = d - 1; r >= 1; r--) cyc(hold, d, 1'b0, 1'b0, act(r));
        cyc(hold, d, 1'b0, 1'b0, fin());
    endtask

    // Monitor: compare DUT outputs against the scoreboard each cycle
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("cycle%0d", cyc_idx), {pulse, busy, done, remaining}, e);
            cyc_idx++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #7;
        check("reset_state", {pulse, busy, done, remaining}, idle());
        @(negedge clk);
        rst = 1'b0;

        // dur=5 with dur changes and a stray start while ACTIVE
        cyc(1'b1, 5, 1'b0, 1'b0, act(5));
        cyc(1'b0, 9, 1'b0, 1'b0, act(4));
        cyc(1'b1, 9, 1'b0, 1'b0, act(3));
        cyc(1'b0, 1, 1'b0, 1'b0, act(2));
        cyc(1'b0, 0, 1'b0, 1'b0, act(1));
        cyc(1'b0, 0, 1'b0, 1'b0, fin());
        cyc(1'b0, 0, 1'b0, 1'b0, idle());

        // dur=0: no pulse, done next cycle, then idle
        cyc(1'b1, 0, 1'b0, 1'b0, fin());
        cyc(1'b0, 0, 1'b0, 1'b0, idle());
        cyc(1'b0, 0, 1'b0, 1'b0, idle());

        // Maximum duration with start held: DONE ignores start, restart from IDLE
        pulse_seq(63, 1'b1);
        cyc(1'b1, 63, 1'b0, 1'b0, idle());
        pulse_seq(63, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, idle());

        // dur=10, abort during the 4th high cycle: 4 cycles high, no done
        cyc(1'b1, 10, 1'b0, 1'b0, act(10));
        cyc(1'b0, 10, 1'b0, 1'b0, act(9));
        cyc(1'b0, 10, 1'b0, 1'b0, act(8));
        cyc(1'b0, 10, 1'b0, 1'b0, act(7));
        cyc(1'b0, 10, 1'b1, 1'b0, idle());
        cyc(1'b0, 10, 1'b0, 1'b0, idle());

        // start together with abort in IDLE: nothing happens
        cyc(1'b1, 5, 1'b1, 1'b0, idle());
        cyc(1'b0, 5, 1'b0, 1'b0, idle());

        // abort at terminal count: no done
        cyc(1'b1, 2, 1'b0, 1'b0, act(2));
        cyc(1'b0, 2, 1'b0, 1'b0, act(1));
        cyc(1'b0, 2, 1'b1, 1'b0, idle());

        // abort during DONE: done already completed its cycle
        cyc(1'b1, 1, 1'b0, 1'b0, act(1));
        cyc(1'b0, 1, 1'b0, 1'b0, fin());
        cyc(1'b0, 1, 1'b1, 1'b0, idle());

        // Async reset mid-pulse on the 7th high cycle
        cyc(1'b1, 20, 1'b0, 1'b0, act(20));
        for (int r = 19; r >= 14; r--) cyc(1'b0, 20, 1'b0, 1'b0, act(r));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", {pulse, busy, done, remaining}, idle());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulse_seq(3, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, idle());

`ifdef PULSE_REPEAT_EN
        // Square wave: 4 high / 4 low, done on each high-to-low edge
        cyc(1'b1, 4, 1'b0, 1'b1, act(4));
        for (int r = 3; r >= 1; r--) cyc(1'b0, 4, 1'b0, 1'b1, act(r));
        cyc(1'b0, 4, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b1, 4));
        for (int r = 3; r >= 1; r--) cyc(1'b0, 4, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, r));
        cyc(1'b0, 4, 1'b0, 1'b1, act(4));
        for (int r = 3; r >= 1; r--) cyc(1'b0, 4, 1'b0, 1'b1, act(r));
        cyc(1'b0, 4, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b1, 4));
        cyc(1'b0, 4, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, 3));
        // Drop rep inside the gap: back to IDLE at gap end
        cyc(1'b0, 4, 1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 2));
        cyc(1'b0, 4, 1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1));
        cyc(1'b0, 4, 1'b0, 1'b0, idle());
        cyc(1'b0, 4, 1'b0, 1'b0, idle());
        cyc(1'b0, 4, 1'b0, 1'b0, idle());
`endif

        // Let the monitor drain the scoreboard
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
